// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream slot scheduler.
//  - MODE_* : encodings of the mode input (4-7 are reserved)
//  - state_e : scheduler policy states
//  - SEL_W, DSx_IDX : stream selector width and stream index constants
//  - mode_to_state / state_to_mode : translation helpers used by the FSM
package stream_mux_pkg;

  localparam int SEL_W = 2;

  localparam logic [2:0] MODE_IDLE  = 3'd0;
  localparam logic [2:0] MODE_FIXED = 3'd1;
  localparam logic [2:0] MODE_ALT   = 3'd2;
  localparam logic [2:0] MODE_ROT   = 3'd3;

  localparam logic [SEL_W-1:0] DS1_IDX = 2'd0;
  localparam logic [SEL_W-1:0] DS2_IDX = 2'd1;
  localparam logic [SEL_W-1:0] DS3_IDX = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIXED = 2'd1,
    ST_ALT   = 2'd2,
    ST_ROT   = 2'd3
  } state_e;

  // Reserved mode values leave the policy where it is.
  function automatic state_e mode_to_state(input logic [2:0] m, input state_e cur);
    state_e s;
    case (m)
      MODE_IDLE:  s = ST_IDLE;
      MODE_FIXED: s = ST_FIXED;
      MODE_ALT:   s = ST_ALT;
      MODE_ROT:   s = ST_ROT;
      default:    s = cur;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] state_to_mode(input state_e s);
    logic [2:0] m;
    case (s)
      ST_FIXED: m = MODE_FIXED;
      ST_ALT:   m = MODE_ALT;
      ST_ROT:   m = MODE_ROT;
      default:  m = MODE_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Slot dwell timer.
//  clk, rst   : clock, asynchronous active-low reset
//  clear      : force the count back to 0 (state change)
//  enable     : count this cycle
//  load       : capture len as the length of the next slot
//  len        : slot length in cycles (0 treated as 1)
//  expire     : last cycle of the current slot (only while enabled)
//  count      : current count, for observation
module dwell_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             expire,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len_eff;

  // The length is captured at slot boundaries so a mid-slot change
  // only affects the following slot.
  assign len_eff = (len_q == '0) ? CNT_W'(1) : len_q;
  assign expire  = enable && (count_q == (len_eff - CNT_W'(1)));
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      len_q   <= '0;
    end else begin
      if (clear || expire) begin
        count_q <= '0;
      end else if (enable) begin
        count_q <= count_q + CNT_W'(1);
      end
      if (load) begin
        len_q <= len;
      end
    end
  end

endmodule

// File: rtl/stream_slot_scheduler.sv
// Time-slot scheduler sharing one output channel between three streams.
//  clk, rst           : clock, asynchronous active-low reset
//  mode               : requested policy 0 idle, 1 fixed, 2 alternate, 3 rotate
//  switch_clk_cycles  : dwell length per slot (0 treated as 1)
//  s_valid/s_ready    : per-stream handshake, s_ready one-hot or zero
//  s_data             : packed streams, DS1 in the low word
//  m_data/m_valid     : registered output stage, m_ready from downstream
//  sel                : active stream index
//  active_mode        : mode currently applied
//  slot_start         : one-cycle pulse in the first cycle of a new slot
//  state_dbg          : current FSM state
//
// Handshake: a beat moves on a channel in any cycle where valid and ready are
// both 1. Valid never depends on ready; once m_valid is high, m_data is held
// until the cycle m_ready is seen. s_ready[sel] is offered only when a
// policy is active and the output register is empty or draining this cycle.
module stream_slot_scheduler
  import stream_mux_pkg::*;
#(
  parameter int NUM_STREAMS = 3,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2:0]                    mode,
  input  logic [CNT_W-1:0]              switch_clk_cycles,
  input  logic [NUM_STREAMS-1:0]        s_valid,
  output logic [NUM_STREAMS-1:0]        s_ready,
  input  logic [NUM_STREAMS*DATA_W-1:0] s_data,
  output logic [DATA_W-1:0]             m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [SEL_W-1:0]              sel,
  output logic [2:0]                    active_mode,
  output logic                          slot_start,
  output logic [1:0]                    state_dbg
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              slot_start_q, slot_start_d;
  logic [DATA_W-1:0] m_data_q;
  logic              m_valid_q;

  logic              state_change;
  logic              timer_en;
  logic              expire;
  logic [CNT_W-1:0]  dwell_count;
  logic              ready_ok;
  logic              accept;
  logic [DATA_W-1:0] sel_data;

  assign timer_en = (state_q == ST_ALT) || (state_q == ST_ROT);

  dwell_timer #(.CNT_W(CNT_W)) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_change),
    .enable (timer_en),
    .load   (state_change || expire),
    .len    (switch_clk_cycles),
    .expire (expire),
    .count  (dwell_count)
  );

  // Next-state, selector and slot pulse.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    slot_start_d = 1'b0;

    case (state_q)
      ST_IDLE:  state_d = mode_to_state(mode, ST_IDLE);
      ST_FIXED: state_d = mode_to_state(mode, ST_FIXED);
      ST_ALT,
      ST_ROT: begin
        if (expire) state_d = mode_to_state(mode, state_q);
      end
      default:  state_d = ST_IDLE;
    endcase

    state_change = (state_d != state_q);

    if (state_change) begin
      // Every new policy starts on DS1.
      sel_d        = DS1_IDX;
      slot_start_d = 1'b1;
    end else if (expire) begin
      if (state_q == ST_ALT) begin
        sel_d = (sel_q == DS1_IDX) ? DS2_IDX : DS1_IDX;
      end else begin
        sel_d = (sel_q == DS3_IDX) ? DS1_IDX : sel_q + SEL_W'(1);
      end
      slot_start_d = (sel_d != sel_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= DS1_IDX;
      slot_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      slot_start_q <= slot_start_d;
    end
  end

  // Input handshake against the current slot.
  assign ready_ok = (state_q != ST_IDLE) && (!m_valid_q || m_ready);
  assign s_ready  = ready_ok ? (NUM_STREAMS'(1) << sel_q) : '0;
  assign accept   = ready_ok && s_valid[sel_q];

  always_comb begin
    sel_data = '0;
    case (sel_q)
      DS1_IDX: sel_data = s_data[0*DATA_W +: DATA_W];
      DS2_IDX: sel_data = s_data[1*DATA_W +: DATA_W];
      DS3_IDX: sel_data = s_data[2*DATA_W +: DATA_W];
      default: sel_data = '0;
    endcase
  end

  // Output register: loads on accept, empties when drained with no refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else if (accept) begin
      m_data_q  <= sel_data;
      m_valid_q <= 1'b1;
    end else if (m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign sel         = sel_q;
  assign active_mode = state_to_mode(state_q);
  assign slot_start  = slot_start_q;
  assign state_dbg   = state_q;

  logic unused_ok;
  assign unused_ok = ^dwell_count;

endmodule

// File: tb/tb_stream_slot_scheduler.sv
module tb_stream_slot_scheduler;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;
  localparam logic [31:0] DS1 = 32'hA5A5_0001;
  localparam logic [31:0] DS2 = 32'hB6B6_0002;
  localparam logic [31:0] DS3 = 32'hC7C7_0003;

  logic              clk;
  logic              rst;
  logic [2:0]        mode;
  logic [CNT_W-1:0]  switch_clk_cycles;
  logic [2:0]        s_valid;
  logic [2:0]        s_ready;
  logic [95:0]       s_data;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [1:0]        sel;
  logic [2:0]        active_mode;
  logic              slot_start;
  logic [1:0]        state_dbg;

  int checks;
  int failures;

  logic [31:0] ds_tab [3];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  stream_slot_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .mode              (mode),
    .switch_clk_cycles (switch_clk_cycles),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_data            (s_data),
    .m_data            (m_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .sel               (sel),
    .active_mode       (active_mode),
    .slot_start        (slot_start),
    .state_dbg         (state_dbg)
  );

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are checked just after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    mode = 3'd0;
    m_ready = 1'b0;
    s_valid = 3'b000;
    switch_clk_cycles = '0;
    step();
    step();
    rst = 1'b1;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    mode = 3'd0;
    m_ready = 1'b1;
    s_valid = 3'b111;
    switch_clk_cycles = '0;
    step();
    step();
    checks++; if (s_ready !== 3'b000) begin failures++; $display("FAIL reset_s_ready got=%b exp=000", s_ready); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    checks++; if (sel !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++; if (m_data !== 32'h0) begin failures++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
    checks++; if (active_mode !== 3'd0) begin failures++; $display("FAIL reset_active_mode got=%0d exp=0", active_mode); end
    checks++; if (slot_start !== 1'b0) begin failures++; $display("FAIL reset_slot_start got=%b exp=0", slot_start); end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (m_valid !== 1'b0 || s_ready !== 3'b000) begin failures++; $display("FAIL idle_no_beats cyc=%0d m_valid=%b s_ready=%b exp 0/000", i, m_valid, s_ready); end
    end
    // A reserved mode value leaves the scheduler idle.
    mode = 3'd5;
    step();
    step();
    checks++; if (state_dbg !== 2'd0 || active_mode !== 3'd0) begin failures++; $display("FAIL reserved_mode_idle state=%0d active_mode=%0d exp 0/0", state_dbg, active_mode); end
  endtask

  task automatic test_fixed();
    apply_reset();
    mode = 3'd1;
    m_ready = 1'b1;
    s_valid = 3'b001;
    step();
    checks++; if (slot_start !== 1'b1) begin failures++; $display("FAIL fixed_slot_start got=%b exp=1", slot_start); end
    checks++; if (active_mode !== 3'd1) begin failures++; $display("FAIL fixed_active_mode got=%0d exp=1", active_mode); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL fixed_first_valid got=%b exp=0", m_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (s_ready !== 3'b001) begin failures++; $display("FAIL fixed_s_ready cyc=%0d got=%b exp=001", i, s_ready); end
      step();
      checks++; if (m_valid !== 1'b1 || m_data !== DS1) begin failures++; $display("FAIL fixed_m_data cyc=%0d got=%b/%h exp=1/%h", i, m_valid, m_data, DS1); end
    end
    checks++; if (slot_start !== 1'b0) begin failures++; $display("FAIL fixed_no_pulse got=%b exp=0", slot_start); end
  endtask

  task automatic test_alternate();
    apply_reset();
    mode = 3'd2;
    switch_clk_cycles = 32'd4;
    m_ready = 1'b1;
    s_valid = 3'b111;
    step();
    for (int i = 0; i < 12; i++) begin
      checks++; if (sel !== 2'((i / 4) % 2)) begin failures++; $display("FAIL alt_sel cyc=%0d got=%0d exp=%0d", i, sel, (i / 4) % 2); end
      checks++; if (slot_start !== (i % 4 == 0)) begin failures++; $display("FAIL alt_slot_start cyc=%0d got=%b exp=%b", i, slot_start, (i % 4 == 0)); end
      if (i >= 1) begin
        checks++; if (m_data !== ds_tab[((i - 1) / 4) % 2]) begin failures++; $display("FAIL alt_m_data cyc=%0d got=%h exp=%h", i, m_data, ds_tab[((i - 1) / 4) % 2]); end
      end
      step();
    end
  endtask

  task automatic test_rotate_fast();
    apply_reset();
    mode = 3'd3;
    switch_clk_cycles = 32'd0;
    m_ready = 1'b1;
    s_valid = 3'b111;
    step();
    for (int i = 0; i < 9; i++) begin
      checks++; if (sel !== 2'(i % 3)) begin failures++; $display("FAIL rot_sel cyc=%0d got=%0d exp=%0d", i, sel, i % 3); end
      checks++; if (slot_start !== 1'b1) begin failures++; $display("FAIL rot_slot_start cyc=%0d got=%b exp=1", i, slot_start); end
      if (i >= 1) begin
        checks++; if (m_valid !== 1'b1 || m_data !== ds_tab[(i - 1) % 3]) begin failures++; $display("FAIL rot_m_data cyc=%0d got=%b/%h exp=1/%h", i, m_valid, m_data, ds_tab[(i - 1) % 3]); end
      end
      step();
    end
  endtask

  task automatic test_stall();
    apply_reset();
    mode = 3'd3;
    switch_clk_cycles = 32'd8;
    m_ready = 1'b1;
    s_valid = 3'b111;
    step();
    for (int c = 0; c < 15; c++) begin
      m_ready = !(c >= 3 && c <= 12);
      #1;
      checks++; if (sel !== 2'((c / 8) % 3)) begin failures++; $display("FAIL stall_sel cyc=%0d got=%0d exp=%0d", c, sel, (c / 8) % 3); end
      if (c >= 3 && c <= 12) begin
        checks++; if (s_ready !== 3'b000) begin failures++; $display("FAIL stall_s_ready cyc=%0d got=%b exp=000", c, s_ready); end
        checks++; if (m_valid !== 1'b1 || m_data !== DS1) begin failures++; $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/%h", c, m_valid, m_data, DS1); end
      end
      if (c == 8) begin
        checks++; if (slot_start !== 1'b1) begin failures++; $display("FAIL stall_slot_start got=%b exp=1", slot_start); end
      end
      if (c == 13) begin
        checks++; if (s_ready !== 3'b010) begin failures++; $display("FAIL stall_release_ready got=%b exp=010", s_ready); end
      end
      if (c == 14) begin
        checks++; if (m_valid !== 1'b1 || m_data !== DS2) begin failures++; $display("FAIL stall_release_data got=%b/%h exp=1/%h", m_valid, m_data, DS2); end
      end
      step();
    end
  endtask

  task automatic test_mode_change();
    logic [1:0] exp_sel;
    apply_reset();
    mode = 3'd2;
    switch_clk_cycles = 32'd6;
    m_ready = 1'b1;
    s_valid = 3'b111;
    step();
    for (int c = 0; c < 16; c++) begin
      if (c == 2) mode = 3'd3;
      if (c == 8) switch_clk_cycles = 32'd2;
      #1;
      exp_sel = (c < 12) ? 2'd0 : (c < 14) ? 2'd1 : 2'd2;
      checks++; if (sel !== exp_sel) begin failures++; $display("FAIL chg_sel cyc=%0d got=%0d exp=%0d", c, sel, exp_sel); end
      checks++; if (active_mode !== ((c < 6) ? 3'd2 : 3'd3)) begin failures++; $display("FAIL chg_active_mode cyc=%0d got=%0d exp=%0d", c, active_mode, (c < 6) ? 2 : 3); end
      checks++; if (slot_start !== (c == 0 || c == 6 || c == 12 || c == 14)) begin failures++; $display("FAIL chg_slot_start cyc=%0d got=%b", c, slot_start); end
      if (c == 15) begin
        rst = 1'b0;
        #1;
        checks++; if (sel !== 2'd0 || active_mode !== 3'd0 || slot_start !== 1'b0) begin failures++; $display("FAIL async_reset_ctrl sel=%0d mode=%0d slot_start=%b exp 0/0/0", sel, active_mode, slot_start); end
        checks++; if (m_valid !== 1'b0 || m_data !== 32'h0 || s_ready !== 3'b000) begin failures++; $display("FAIL async_reset_out m_valid=%b m_data=%h s_ready=%b exp 0/0/000", m_valid, m_data, s_ready); end
      end else begin
        step();
      end
    end
    rst = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    failures = 0;
    ds_tab[0] = DS1;
    ds_tab[1] = DS2;
    ds_tab[2] = DS3;
    s_data = {DS3, DS2, DS1};
    test_reset();
    test_fixed();
    test_alternate();
    test_rotate_fast();
    test_stall();
    test_mode_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
